// File: rtl/uart_byte_receiver.sv
// Purpose : 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined), one byte out per frame.
// Latency : strobe one clk after the stop-bit mid-sample (~9.5 bit times + 3 clk after the start edge).
// Backpr. : none; the consumer must take data_stream_out on the strobe cycle, the next byte overwrites it.
//
// Ports:
//   clk                 system clock, rising edge
//   rst                 asynchronous active-high reset
//   rx                  serial line, idle high, asynchronous to clk
//   data_stream_out     last good byte, held between frames
//   data_stream_out_stb one-cycle pulse: new byte on data_stream_out
//   framing_err         one-cycle pulse: stop bit sampled low
//   parity_err          one-cycle pulse: even-parity mismatch (constant 0 without UART_RX_PARITY_EN)
//
// Optional feature macro: UART_RX_PARITY_EN (adds an even parity bit between data and stop).
module uart_byte_receiver #(
    parameter int P_BAUD_RATE       = 115200,
    parameter int P_CLOCK_FREQUENCY = 100_000_000,
    parameter int P_OVERSAMPLE      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_stream_out,
    output logic       data_stream_out_stb,
    output logic       framing_err,
    output logic       parity_err
);

    localparam int DIV_RAW = P_CLOCK_FREQUENCY / (P_BAUD_RATE * P_OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW      = $clog2(P_OVERSAMPLE);

    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [SW-1:0] HALF_LAST = SW'(P_OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] BIT_LAST  = SW'(P_OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state_q;
    logic            rx_meta_q;
    logic            rx_s_q;
    logic [TW-1:0]   tick_cnt_q;
    logic [TW-1:0]   tick_cnt_d;
    logic            tick;
    logic [SW-1:0]   samp_cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic [7:0]      data_q;
    logic            stb_q;
    logic            ferr_q;
    logic            perr_q;
    logic            par_bad;

    // Synchroniser resets to the idle level so reset release never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Tick counter is held at zero while idle, so every frame's sample grid
    // is phase-aligned to the detected start edge.
    assign tick = (tick_cnt_q == TICK_LAST);

    always_comb begin
        tick_cnt_d = tick_cnt_q + 1'b1;
        if (state_q == S_IDLE || tick) begin
            tick_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_q;
    // Even parity: data ones plus the parity bit must be even.
    assign par_bad = (^shift_q) ^ parity_q;
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            samp_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            stb_q      <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            stb_q  <= 1'b0;
            ferr_q <= 1'b0;
            perr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    samp_cnt_q <= '0;
                    bit_idx_q  <= '0;
                    if (!rx_s_q) begin
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (samp_cnt_q == HALF_LAST) begin
                            samp_cnt_q <= '0;
                            bit_idx_q  <= '0;
                            // A line already back high at mid-start was a glitch.
                            state_q    <= rx_s_q ? S_IDLE : S_DATA;
                        end else begin
                            samp_cnt_q <= samp_cnt_q + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (samp_cnt_q == BIT_LAST) begin
                            samp_cnt_q <= '0;
                            shift_q    <= {rx_s_q, shift_q[7:1]};
                            bit_idx_q  <= bit_idx_q + 1'b1;
                            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state_q <= S_PARITY;
`else
                                state_q <= S_STOP;
`endif
                            end
                        end else begin
                            samp_cnt_q <= samp_cnt_q + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        if (samp_cnt_q == BIT_LAST) begin
                            samp_cnt_q <= '0;
                            parity_q   <= rx_s_q;
                            state_q    <= S_STOP;
                        end else begin
                            samp_cnt_q <= samp_cnt_q + 1'b1;
                        end
                    end
                end
`endif
                S_STOP: begin
                    if (tick) begin
                        if (samp_cnt_q == BIT_LAST) begin
                            samp_cnt_q <= '0;
                            perr_q     <= par_bad;
                            if (rx_s_q) begin
                                if (!par_bad) begin
                                    data_q <= shift_q;
                                    stb_q  <= 1'b1;
                                end
                                state_q <= S_IDLE;
                            end else begin
                                ferr_q  <= 1'b1;
                                state_q <= S_BREAK;
                            end
                        end else begin
                            samp_cnt_q <= samp_cnt_q + 1'b1;
                        end
                    end
                end
                S_BREAK: begin
                    // Stay here for the whole low period so a break reports once.
                    if (rx_s_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign data_stream_out     = data_q;
    assign data_stream_out_stb = stb_q;
    assign framing_err         = ferr_q;
    assign parity_err          = perr_q;

endmodule

// File: tb/tb_uart_byte_receiver.sv
module tb_uart_byte_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data_stream_out;
    logic       data_stream_out_stb;
    logic       framing_err;
    logic       parity_err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int stb_cnt = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int lat;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    logic [7:0] part_b;
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_byte_receiver #(
        .P_BAUD_RATE      (115200),
        .P_CLOCK_FREQUENCY(1_843_200),
        .P_OVERSAMPLE     (16)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .rx                 (rx),
        .data_stream_out    (data_stream_out),
        .data_stream_out_stb(data_stream_out_stb),
        .framing_err        (framing_err),
        .parity_err         (parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard pop on every strobe, plus pulse counters.
    always @(negedge clk) begin
        if (!rst) begin
            if (data_stream_out_stb) begin
                stb_cnt++;
                chk("stb_not_with_ferr", {31'd0, framing_err}, 32'd0);
                chk("stb_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    chk("byte", {24'd0, data_stream_out}, {24'd0, mon_exp});
                end
                lat = cyc - fall_cyc;
                tests++;
                assert (lat >= 154 && lat <= 156) else begin
                    fails++;
                    $error("FAIL latency: observed %0d expected 155 +/-1", lat);
                end
            end
            if (framing_err) ferr_cnt++;
            if (parity_err) perr_cnt++;
        end
    end

    // Drives one full frame starting at a negedge; returns at a negedge with the line idle.
    task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        fall_cyc = cyc;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        repeat (16) @(negedge clk);
`endif
        rx = stop_bit;
        repeat (16) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_ok(input logic [7:0] b);
        exp_q.push_back(b);
        drive_frame(b, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_data", {24'd0, data_stream_out}, 32'h00);
        chk("rst_stb", {31'd0, data_stream_out_stb}, 32'd0);
        chk("rst_ferr", {31'd0, framing_err}, 32'd0);
        chk("rst_perr", {31'd0, parity_err}, 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Single frame
        send_ok(8'hA5);
        repeat (10) @(negedge clk);
        chk("a5_stb_cnt", stb_cnt, 1);
        chk("a5_ferr_cnt", ferr_cnt, 0);
        chk("a5_data", {24'd0, data_stream_out}, 32'hA5);

        // Back-to-back frames, no idle gap
        send_ok(8'h00);
        send_ok(8'hFF);
        send_ok(8'h3C);
        repeat (10) @(negedge clk);
        chk("b2b_stb_cnt", stb_cnt, 4);
        chk("b2b_ferr_cnt", ferr_cnt, 0);
        chk("b2b_data_held", {24'd0, data_stream_out}, 32'h3C);
        chk("b2b_queue_empty", exp_q.size(), 0);

        // Short low glitch must be rejected
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (60) @(negedge clk);
        chk("glitch_stb_cnt", stb_cnt, 4);
        chk("glitch_ferr_cnt", ferr_cnt, 0);
        send_ok(8'h81);
        repeat (10) @(negedge clk);
        chk("post_glitch_stb_cnt", stb_cnt, 5);
        chk("post_glitch_data", {24'd0, data_stream_out}, 32'h81);

        // Stop bit low followed by a 30-bit break
        drive_frame(8'h55, 1'b0);
        rx = 1'b0;
        repeat (30 * 16) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("break_ferr_cnt", ferr_cnt, 1);
        chk("break_stb_cnt", stb_cnt, 5);
        chk("break_data_kept", {24'd0, data_stream_out}, 32'h81);
        send_ok(8'h12);
        repeat (10) @(negedge clk);
        chk("post_break_stb_cnt", stb_cnt, 6);
        chk("post_break_data", {24'd0, data_stream_out}, 32'h12);
        chk("post_break_ferr_cnt", ferr_cnt, 1);

        // Reset in the middle of data bit 4
        part_b = 8'h5A;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = part_b[i];
            repeat (16) @(negedge clk);
        end
        rx = part_b[4];
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_data", {24'd0, data_stream_out}, 32'h00);
        chk("midrst_stb", {31'd0, data_stream_out_stb}, 32'd0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("midrst_stb_cnt", stb_cnt, 6);
        send_ok(8'hC3);
        repeat (10) @(negedge clk);
        chk("post_rst_stb_cnt", stb_cnt, 7);
        chk("post_rst_data", {24'd0, data_stream_out}, 32'hC3);

`ifdef UART_RX_PARITY_EN
        // Correct even parity accepted, wrong parity flagged and dropped
        par_flip = 1'b0;
        send_ok(8'h07);
        repeat (10) @(negedge clk);
        chk("par_ok_stb_cnt", stb_cnt, 8);
        chk("par_ok_perr_cnt", perr_cnt, 0);
        chk("par_ok_data", {24'd0, data_stream_out}, 32'h07);
        par_flip = 1'b1;
        drive_frame(8'h07, 1'b1);
        par_flip = 1'b0;
        repeat (10) @(negedge clk);
        chk("par_bad_perr_cnt", perr_cnt, 1);
        chk("par_bad_stb_cnt", stb_cnt, 8);
        chk("par_bad_ferr_cnt", ferr_cnt, 1);
`else
        send_ok(8'h07);
        repeat (10) @(negedge clk);
        chk("nopar_stb_cnt", stb_cnt, 8);
        chk("nopar_data", {24'd0, data_stream_out}, 32'h07);
        chk("nopar_perr_cnt", perr_cnt, 0);
`endif

        chk("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
